// File: rtl/acc_pkg.sv
// rtl/acc_pkg.sv - shared constants and extended request/response types for the accelerator interface
package acc_pkg;

    localparam int unsigned MaxIdWidth   = 5;
    localparam int unsigned AccNumReq    = 2;
    localparam int unsigned AccDataWidth = 32;

    function automatic int unsigned idx_width(input int unsigned num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int unsigned ext_id_width(input int unsigned num_req);
        return MaxIdWidth + idx_width(num_req);
    endfunction

    localparam int unsigned ExtIdWidth = ext_id_width(AccNumReq);

    typedef struct packed {
        logic [31:0]           operand;
        logic [ExtIdWidth-1:0] id;
    } acc_ext_req_chan_t;

    typedef struct packed {
        acc_ext_req_chan_t q;
        logic              q_valid;
        logic              p_ready;
    } acc_ext_req_t;

    typedef struct packed {
        logic [AccDataWidth-1:0] data;
        logic                    error;
        logic [ExtIdWidth-1:0]   id;
    } acc_ext_rsp_chan_t;

    typedef struct packed {
        acc_ext_rsp_chan_t p;
        logic              p_valid;
        logic              q_ready;
    } acc_ext_rsp_t;

endpackage

// File: rtl/acc_id_fifo.sv
// rtl/acc_id_fifo.sv - in-order FIFO of extended IDs for requests awaiting a result
module acc_id_fifo #(
    parameter int unsigned Depth   = 4,
    parameter int unsigned IdWidth = 6
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [IdWidth-1:0]           id_i,
    input  logic                         pop_i,
    output logic [IdWidth-1:0]           head_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(Depth+1)-1:0]   count_o
);
    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [IdWidth-1:0] mem_q [Depth];
    logic [PtrW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0]    count_q, count_d;

    assign head_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == CntW'(Depth));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

    // Pointers wrap at Depth, which need not be a power of two.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = (wr_ptr_q == PtrW'(Depth - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_i) begin
            rd_ptr_d = (rd_ptr_q == PtrW'(Depth - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_i, pop_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push_i) begin
                mem_q[wr_ptr_q] <= id_i;
            end
        end
    end

    a_no_push_full: assert property (@(posedge clk_i) disable iff (!rst_ni) !(push_i && full_o))
        else $error("acc_id_fifo: push while full");
    a_no_pop_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(pop_i && empty_o))
        else $error("acc_id_fifo: pop while empty");

endmodule

// File: rtl/acc_responder.sv
// rtl/acc_responder.sv - slave endpoint: forwards requests to an in-order unit and rebuilds ID-tagged responses
module acc_responder
    import acc_pkg::*;
#(
    parameter int unsigned DataWidth      = AccDataWidth,
    parameter int unsigned IdWidth        = ExtIdWidth,
    parameter int unsigned MaxOutstanding = 4,
    parameter type ext_req_t              = acc_ext_req_t,
    parameter type ext_rsp_t              = acc_ext_rsp_t,
    parameter type ext_req_chan_t         = acc_ext_req_chan_t
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  ext_req_t                              slv_req_i,
    output ext_rsp_t                              slv_rsp_o,
    output ext_req_chan_t                         op_o,
    output logic                                  op_valid_o,
    input  logic                                  op_ready_i,
    input  logic [DataWidth-1:0]                  res_data_i,
    input  logic                                  res_error_i,
    input  logic                                  res_valid_i,
    output logic                                  res_ready_o,
    output logic [$clog2(MaxOutstanding+1)-1:0]   outstanding_o
);
    logic               full, empty;
    logic               q_ready, push, pop;
    logic [IdWidth-1:0] head_id;

    logic [DataWidth-1:0] p_data_q, p_data_d;
    logic                 p_error_q, p_error_d;
    logic [IdWidth-1:0]   p_id_q, p_id_d;
    logic                 p_valid_q, p_valid_d;

    // Full blocks the request even if a pop happens this cycle: no ready path through the result side.
    assign q_ready     = op_ready_i && !full;
    assign op_o        = slv_req_i.q;
    assign op_valid_o  = slv_req_i.q_valid && !full;
    assign push        = slv_req_i.q_valid && q_ready;
    assign res_ready_o = !empty && (!p_valid_q || slv_req_i.p_ready);
    assign pop         = res_valid_i && res_ready_o;

    acc_id_fifo #(
        .Depth   (MaxOutstanding),
        .IdWidth (IdWidth)
    ) u_id_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (push),
        .id_i    (slv_req_i.q.id),
        .pop_i   (pop),
        .head_o  (head_id),
        .full_o  (full),
        .empty_o (empty),
        .count_o (outstanding_o)
    );

    always_comb begin
        p_data_d  = p_data_q;
        p_error_d = p_error_q;
        p_id_d    = p_id_q;
        p_valid_d = p_valid_q;
        if (pop) begin
            p_data_d  = res_data_i;
            p_error_d = res_error_i;
            p_id_d    = head_id;
            p_valid_d = 1'b1;
        end else if (slv_req_i.p_ready) begin
            p_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            p_data_q  <= '0;
            p_error_q <= 1'b0;
            p_id_q    <= '0;
            p_valid_q <= 1'b0;
        end else begin
            p_data_q  <= p_data_d;
            p_error_q <= p_error_d;
            p_id_q    <= p_id_d;
            p_valid_q <= p_valid_d;
        end
    end

    always_comb begin
        slv_rsp_o         = '0;
        slv_rsp_o.p.data  = p_data_q;
        slv_rsp_o.p.error = p_error_q;
        slv_rsp_o.p.id    = p_id_q;
        slv_rsp_o.p_valid = p_valid_q;
        slv_rsp_o.q_ready = q_ready;
    end

    a_p_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
        p_valid_q && !slv_req_i.p_ready |=> p_valid_q && $stable({p_data_q, p_error_q, p_id_q}))
        else $error("acc_responder: response changed under backpressure");
    a_res_when_empty: assert property (@(posedge clk_i) disable iff (!rst_ni) !(res_valid_i && empty))
        else $error("acc_responder: unit produced a result with nothing outstanding");

endmodule

// File: tb/tb_acc_responder.sv
// tb/tb_acc_responder.sv - directed and random checks of acc_responder against a queue-based reference model
module tb_acc_responder;
    import acc_pkg::*;

    localparam int unsigned MaxOut = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    acc_ext_req_t      req;
    acc_ext_rsp_t      rsp;
    acc_ext_req_chan_t op;
    logic              op_valid, op_ready;
    logic [31:0]       res_data;
    logic              res_error, res_valid, res_ready;
    logic [2:0]        outstanding;

    int n_checks = 0;
    int n_fail   = 0;

    logic [5:0]        inflight[$];
    logic [5:0]        issued[$];
    acc_ext_rsp_chan_t got[$];
    logic              exp_pv;
    acc_ext_rsp_chan_t exp_p;

    always #5 clk = ~clk;

    acc_responder #(
        .MaxOutstanding (MaxOut)
    ) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .slv_req_i     (req),
        .slv_rsp_o     (rsp),
        .op_o          (op),
        .op_valid_o    (op_valid),
        .op_ready_i    (op_ready),
        .res_data_i    (res_data),
        .res_error_i   (res_error),
        .res_valid_i   (res_valid),
        .res_ready_o   (res_ready),
        .outstanding_o (outstanding)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        inflight.delete();
        exp_pv = 1'b0;
        exp_p  = '0;
    endtask

    // One clock: drive inputs, check combinational outputs mid-cycle, advance the model, check after the edge.
    task automatic tick(input logic qv, input logic [5:0] id, input logic opr,
                        input logic rv, input logic [31:0] d, input logic e, input logic pr);
        logic full, acc, pop;
        req.q.operand = $urandom;
        req.q.id      = id;
        req.q_valid   = qv;
        req.p_ready   = pr;
        op_ready      = opr;
        res_valid     = rv;
        res_data      = d;
        res_error     = e;
        @(negedge clk);
        full = (inflight.size() == MaxOut);
        chk("q_ready", rsp.q_ready, opr && !full);
        chk("op_valid", op_valid, qv && !full);
        chk("op_payload", op, req.q);
        chk("res_ready", res_ready, (inflight.size() > 0) && (!exp_pv || pr));
        chk("p_valid", rsp.p_valid, exp_pv);
        if (exp_pv) chk("p_payload", rsp.p, exp_p);
        if (rsp.p_valid && pr) got.push_back(rsp.p);
        acc = qv && opr && !full;
        pop = rv && (inflight.size() > 0) && (!exp_pv || pr);
        if (pop) begin
            exp_p.id    = inflight.pop_front();
            exp_p.data  = d;
            exp_p.error = e;
            exp_pv      = 1'b1;
        end else if (pr) begin
            exp_pv = 1'b0;
        end
        if (acc) begin
            inflight.push_back(id);
            issued.push_back(id);
        end
        @(posedge clk);
        #1;
        chk("outstanding", outstanding, inflight.size());
    endtask

    task automatic idle(input logic pr);
        tick(1'b0, 6'h0, 1'b1, 1'b0, 32'h0, 1'b0, pr);
    endtask

    initial begin
        int guard;
        rst_n     = 1'b0;
        req       = '0;
        op_ready  = 1'b0;
        res_data  = '0;
        res_error = 1'b0;
        res_valid = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_p_valid", rsp.p_valid, 1'b0);
        chk("reset_p", rsp.p, '0);
        chk("reset_outstanding", outstanding, 0);
        chk("reset_op_valid", op_valid, 1'b0);
        chk("reset_res_ready", res_ready, 1'b0);
        rst_n = 1'b1;

        // Single op with a three-cycle unit latency.
        got.delete();
        tick(1'b1, 6'h25, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("single_outstanding1", outstanding, 1);
        idle(1'b1);
        idle(1'b1);
        tick(1'b0, 6'h0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
        chk("single_p_valid", rsp.p_valid, 1'b1);
        chk("single_p_id", rsp.p.id, 6'h25);
        chk("single_p_data", rsp.p.data, 32'hDEAD_BEEF);
        chk("single_p_error", rsp.p.error, 1'b0);
        chk("single_outstanding0", outstanding, 0);
        idle(1'b1);

        // Fill with results stalled, then release in order.
        got.delete();
        for (int i = 1; i <= 4; i++) tick(1'b1, 6'(i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("fill_outstanding", outstanding, 4);
        chk("fill_q_ready", rsp.q_ready, 1'b0);
        tick(1'b1, 6'h5, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        for (int i = 1; i <= 4; i++) tick(1'b0, 6'h0, 1'b1, 1'b1, 32'h100 + 32'(i), 1'b0, 1'b1);
        idle(1'b1);
        chk("fill_count", got.size(), 4);
        for (int i = 0; i < 4 && i < got.size(); i++) chk("fill_order", got[i].id, 6'(i + 1));

        // Backpressure: response held for five cycles with a second result waiting.
        tick(1'b1, 6'd10, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 6'd11, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 6'h0, 1'b1, 1'b1, 32'hAAAA_0001, 1'b0, 1'b0);
        repeat (5) tick(1'b0, 6'h0, 1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b0);
        chk("bp_hold_data", rsp.p.data, 32'hAAAA_0001);
        chk("bp_res_ready", res_ready, 1'b0);
        got.delete();
        tick(1'b0, 6'h0, 1'b1, 1'b1, 32'hBBBB_0002, 1'b0, 1'b1);
        tick(1'b0, 6'h0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        chk("bp_count", got.size(), 2);
        if (got.size() == 2) begin
            chk("bp_first", {got[0].id, got[0].data}, {6'd10, 32'hAAAA_0001});
            chk("bp_second", {got[1].id, got[1].data}, {6'd11, 32'hBBBB_0002});
        end

        // Full FIFO: pop and blocked push in the same cycle.
        for (int i = 20; i < 24; i++) tick(1'b1, 6'(i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 6'd24, 1'b1, 1'b1, 32'h1234, 1'b0, 1'b1);
        chk("simul_outstanding", outstanding, 3);
        for (int i = 0; i < 3; i++) tick(1'b0, 6'h0, 1'b1, 1'b1, $urandom, 1'b0, 1'b1);
        idle(1'b1);

        // Ten sequential ops wrap the pointers; only op 7 reports an error.
        got.delete();
        for (int i = 0; i < 10; i++) begin
            tick(1'b1, 6'(i), 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
            tick(1'b0, 6'h0, 1'b1, 1'b1, $urandom, (i == 7), 1'b1);
        end
        idle(1'b1);
        chk("wrap_count", got.size(), 10);
        for (int i = 0; i < 10 && i < got.size(); i++)
            chk("wrap_id_err", {got[i].id, got[i].error}, {6'(i), (i == 7) ? 1'b1 : 1'b0});

        // Random traffic; responses must come back in request order.
        got.delete();
        issued.delete();
        for (int c = 0; c < 400; c++) begin
            tick($urandom_range(0, 1), 6'($urandom), $urandom_range(0, 3) != 0,
                 (inflight.size() > 0) && ($urandom_range(0, 1) == 1), $urandom,
                 $urandom_range(0, 7) == 0, $urandom_range(0, 2) != 0);
        end
        guard = 0;
        while ((inflight.size() > 0 || exp_pv) && guard < 50) begin
            tick(1'b0, 6'h0, 1'b1, inflight.size() > 0, $urandom, 1'b0, 1'b1);
            guard++;
        end
        chk("rand_drained", inflight.size() + int'(exp_pv), 0);
        chk("rand_count", got.size(), issued.size());
        for (int i = 0; i < got.size() && i < issued.size(); i++) chk("rand_order", got[i].id, issued[i]);

        // Asynchronous reset with two IDs in flight and a response pending.
        tick(1'b1, 6'd30, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b1, 6'd31, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
        tick(1'b1, 6'd32, 1'b1, 1'b1, 32'h5555, 1'b0, 1'b0);
        chk("pre_reset_outstanding", outstanding, 2);
        req.q_valid = 1'b0;
        res_valid   = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_p_valid", rsp.p_valid, 1'b0);
        chk("arst_outstanding", outstanding, 0);
        chk("arst_p", rsp.p, '0);
        model_reset();
        @(posedge clk);
        #1 rst_n = 1'b1;
        got.delete();
        idle(1'b1);
        chk("post_reset_res_ready", res_ready, 1'b0);
        idle(1'b1);
        tick(1'b1, 6'd33, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1);
        tick(1'b0, 6'h0, 1'b1, 1'b1, 32'h7777, 1'b0, 1'b1);
        idle(1'b1);
        chk("post_reset_count", got.size(), 1);
        if (got.size() == 1) chk("post_reset_id", got[0].id, 6'd33);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
